// File: rtl/fp_lut_array_precompute_stage1.sv
`default_nettype none
// ============================================================================
// fp_lut_array_precompute_stage1 : builds the per-row signed-sum FP table
// a_lut by doubling, one level per cycle.  Rev 1.0
// ============================================================================

module fp_lut_array_precompute_stage1 #(
  parameter int SIG_WIDTH       = 10,
  parameter int EXP_WIDTH       = 5,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int A_LUT_BIT       = SIG_WIDTH + EXP_WIDTH + 1,
  parameter int M_DIM           = 2,
  parameter int K_DIM           = 4,
  parameter int A_LUT_DIM       = 2 ** (K_DIM - 1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         act_valid,
  output logic                                         act_ready,
  input  logic [M_DIM-1:0][K_DIM-1:0][A_LUT_BIT-1:0]   act,
  output logic                                         lut_valid,
  input  logic                                         lut_ready,
  output logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] a_lut
);

  localparam int c_lvl_w = $clog2(K_DIM);
  localparam int c_half  = A_LUT_DIM / 2;
  localparam int c_mw    = SIG_WIDTH + 4;
  localparam int c_msb   = A_LUT_BIT - 1;
  localparam logic [EXP_WIDTH+1:0] c_e_one = {{(EXP_WIDTH+1){1'b0}}, 1'b1};
  localparam logic [c_lvl_w-1:0]   c_last  = c_lvl_w'(K_DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                                         state_q;
  logic [c_lvl_w-1:0]                             level_q;
  logic [M_DIM-1:0][K_DIM-1:0][A_LUT_BIT-1:0]     act_q;
  logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] work_q;
  logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] work_d;
  logic [M_DIM-1:0][A_LUT_DIM-1:0][A_LUT_BIT-1:0] a_lut_q;
  logic                                           act_ready_q;
  logic                                           lut_valid_q;

  logic [M_DIM-1:0][A_LUT_BIT-1:0]                w_act_sel;
  logic [M_DIM-1:0][c_half-1:0][A_LUT_BIT-1:0]    w_add;
  logic [M_DIM-1:0][c_half-1:0][A_LUT_BIT-1:0]    w_sub;

  // Round-to-nearest-even FP adder; denormals are flushed to zero and
  // exponent-all-ones operands are treated as infinity unless IEEE mode.
  function automatic logic [A_LUT_BIT-1:0] fp_add(input logic [A_LUT_BIT-1:0] x,
                                                  input logic [A_LUT_BIT-1:0] y);
    logic                  sa, sb, st, rnd_up, nan_a, nan_b;
    logic [EXP_WIDTH-1:0]  ea, eb, ex, ey, d;
    logic [SIG_WIDTH-1:0]  fa, fb, fx, fy;
    logic [c_mw-1:0]       mbx, mbs;
    logic [c_mw:0]         mr;
    logic [SIG_WIDTH+1:0]  mant;
    logic [EXP_WIDTH+1:0]  er;
    logic [A_LUT_BIT-1:0]  res;
    ex = x[c_msb-1:SIG_WIDTH];
    ey = y[c_msb-1:SIG_WIDTH];
    fx = (ex == '0) ? '0 : x[SIG_WIDTH-1:0];
    fy = (ey == '0) ? '0 : y[SIG_WIDTH-1:0];
    if ({ey, fy} > {ex, fx}) begin
      sa = y[c_msb]; ea = ey; fa = fy;
      sb = x[c_msb]; eb = ex; fb = fx;
    end else begin
      sa = x[c_msb]; ea = ex; fa = fx;
      sb = y[c_msb]; eb = ey; fb = fy;
    end
    res    = '0;
    d      = '0;
    st     = 1'b0;
    rnd_up = 1'b0;
    mbx    = '0;
    mbs    = '0;
    mr     = '0;
    mant   = '0;
    er     = '0;
    nan_a  = (ea == '1) && (fa != '0);
    nan_b  = (eb == '1) && (fb != '0);
    if (ea == '1 || eb == '1) begin
      if (IEEE_COMPLIANCE != 0 && (nan_a || nan_b || (ea == '1 && eb == '1 && sa != sb)))
        res = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
      else
        res = {sa, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
    end else if (eb == '0) begin
      res = (ea == '0) ? {sa & sb, {(A_LUT_BIT-1){1'b0}}} : {sa, ea, fa};
    end else begin
      d   = ea - eb;
      mbx = {1'b1, fb, 3'b000};
      mbs = mbx >> d;
      st  = |(mbx & ~({c_mw{1'b1}} << d));
      mbs[0] = mbs[0] | st;
      if (sa == sb) mr = {2'b01, fa, 3'b000} + {1'b0, mbs};
      else          mr = {2'b01, fa, 3'b000} - {1'b0, mbs};
      er = {2'b00, ea};
      if (mr != '0) begin
        if (mr[c_mw]) begin
          mr = {1'b0, mr[c_mw:2], mr[1] | mr[0]};
          er = er + c_e_one;
        end else begin
          for (int k = 0; k < c_mw; k++) begin
            if (!mr[c_mw-1]) begin
              mr = mr << 1;
              er = er - c_e_one;
            end
          end
        end
        rnd_up = mr[2] & (mr[1] | mr[0] | mr[3]);
        mant   = {1'b0, mr[c_mw-1:3]} + {{(SIG_WIDTH+1){1'b0}}, rnd_up};
        if (mant[SIG_WIDTH+1]) begin
          mant = mant >> 1;
          er   = er + c_e_one;
        end
        if (er[EXP_WIDTH+1] || er == '0)
          res = {sa, {(A_LUT_BIT-1){1'b0}}};
        else if (er[EXP_WIDTH:0] >= {1'b0, {EXP_WIDTH{1'b1}}})
          res = {sa, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        else
          res = {sa, er[EXP_WIDTH-1:0], mant[SIG_WIDTH-1:0]};
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < M_DIM; i++) begin : g_row
    assign w_act_sel[i] = act_q[i][level_q];
    for (genvar j = 0; j < c_half; j++) begin : g_add
      assign w_add[i][j] = fp_add(work_q[i][j], w_act_sel[i]);
      assign w_sub[i][j] = fp_add(work_q[i][j], {~w_act_sel[i][c_msb], w_act_sel[i][c_msb-1:0]});
    end
  end

  // Level L splits each of the first 2**(L-1) entries into a -/+ pair.
  always_comb begin
    work_d = work_q;
    for (int l = 1; l < K_DIM; l++) begin
      if (level_q == c_lvl_w'(l)) begin
        for (int i = 0; i < M_DIM; i++) begin
          for (int j = 0; j < (1 << (l - 1)); j++) begin
            work_d[i][j + (1 << (l - 1))] = w_add[i][j];
            work_d[i][j]                  = w_sub[i][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      act_q       <= '0;
      work_q      <= '0;
      a_lut_q     <= '0;
      act_ready_q <= 1'b1;
      lut_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act_valid) begin
            act_q <= act;
            for (int i = 0; i < M_DIM; i++)
              work_q[i][0] <= {~act[i][0][c_msb], act[i][0][c_msb-1:0]};
            level_q     <= c_lvl_w'(1);
            state_q     <= BUILD;
            act_ready_q <= 1'b0;
          end
        end
        BUILD: begin
          work_q <= work_d;
          if (level_q == c_last) begin
            a_lut_q     <= work_d;
            state_q     <= DONE;
            lut_valid_q <= 1'b1;
          end else begin
            level_q <= level_q + c_lvl_w'(1);
          end
        end
        DONE: begin
          if (lut_ready) begin
            state_q     <= IDLE;
            lut_valid_q <= 1'b0;
            act_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          lut_valid_q <= 1'b0;
          act_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign act_ready = act_ready_q;
  assign lut_valid = lut_valid_q;
  assign a_lut     = a_lut_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_lut_array_precompute_stage1.sv
`default_nettype none
// Bench for fp_lut_array_precompute_stage1: activations are multiples of 1/16
// so every table entry is exact and is predicted with integer sums.

module tb_fp_lut_array_precompute_stage1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic                   act_valid4 = 1'b0;
  logic                   act_ready4;
  logic [1:0][3:0][15:0]  act4       = '0;
  logic                   lut_valid4;
  logic                   lut_ready4 = 1'b0;
  logic [1:0][7:0][15:0]  a_lut4;

  logic                   act_valid2 = 1'b0;
  logic                   act_ready2;
  logic [1:0][1:0][15:0]  act2       = '0;
  logic                   lut_valid2;
  logic                   lut_ready2 = 1'b0;
  logic [1:0][1:0][15:0]  a_lut2;

  int checks = 0;
  int errors = 0;
  int grp[16][2][4];
  logic [15:0] spec_val[4] = '{16'hC380, 16'h3400, 16'hC280, 16'h3F00};
  int          spec_idx[4] = '{0, 1, 4, 7};

  always #5 clk = ~clk;

  fp_lut_array_precompute_stage1 #(.M_DIM(2), .K_DIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .act_valid(act_valid4), .act_ready(act_ready4), .act(act4),
    .lut_valid(lut_valid4), .lut_ready(lut_ready4), .a_lut(a_lut4)
  );

  fp_lut_array_precompute_stage1 #(.M_DIM(2), .K_DIM(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .act_valid(act_valid2), .act_ready(act_ready2), .act(act2),
    .lut_valid(lut_valid2), .lut_ready(lut_ready2), .a_lut(a_lut2)
  );

  // Exact half-precision encoding of n/16.
  function automatic logic [15:0] q2h(input int n);
    int a, p, e, m;
    logic s;
    if (n == 0) return 16'h0000;
    s = (n < 0);
    a = s ? -n : n;
    p = 0;
    for (int b = 0; b < 16; b++) if (a >= (1 << b)) p = b;
    e = p + 11;
    m = (a << (10 - p)) & 32'h3FF;
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic int expv(input int g, input int i, input int t, input int kd);
    int v;
    v = -grp[g][i][0];
    for (int k = 1; k < kd; k++)
      v += (((t >> (k - 1)) & 1) != 0) ? grp[g][i][k] : -grp[g][i][k];
    return v;
  endfunction

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randgrp(input int g);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        grp[g][i][k] = int'($urandom_range(128, 0)) - 64;
  endtask

  task automatic load4(input int g);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        act4[i][k] = q2h(grp[g][i][k]);
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    do begin
      do_cycle();
      lat++;
    end while (lut_valid4 !== 1'b1 && lat < 20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    do_cycle();
    checks++;
    if (lut_valid4 !== 1'b0 || act_ready4 !== 1'b1 || a_lut4 !== '0) begin
      errors++;
      $display("FAIL reset4: got valid=%b ready=%b lut=%h required 0 1 0", lut_valid4, act_ready4, a_lut4);
    end
    checks++;
    if (lut_valid2 !== 1'b0 || act_ready2 !== 1'b1 || a_lut2 !== '0) begin
      errors++;
      $display("FAIL reset2: got valid=%b ready=%b lut=%h required 0 1 0", lut_valid2, act_ready2, a_lut2);
    end
    rst_n = 1'b1;
    do_cycle();
    checks++;
    if (act_ready4 !== 1'b1 || lut_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b required 1 0", act_ready4, lut_valid4);
    end
  endtask

  task automatic test_basic();
    int lat, v;
    logic [15:0] e;
    randgrp(0);
    grp[0][0] = '{16, 32, 8, 4};
    load4(0);
    lut_ready4 = 1'b1;
    act_valid4 = 1'b1;
    do_cycle();
    act_valid4 = 1'b0;
    act4 = {$urandom, $urandom, $urandom, $urandom};
    checks++;
    if (act_ready4 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: act_ready=%b required 0", act_ready4);
    end
    wait_valid4(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 3", lat);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (a_lut4[0][spec_idx[n]] !== spec_val[n]) begin
        errors++;
        $display("FAIL basic_spec[0][%0d]: got %h required %h", spec_idx[n], a_lut4[0][spec_idx[n]], spec_val[n]);
      end
    end
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < 8; t++) begin
        v = expv(0, i, t, 4);
        e = q2h(v);
        checks++;
        if ((v == 0) ? (a_lut4[i][t][14:0] !== 15'h0) : (a_lut4[i][t] !== e)) begin
          errors++;
          $display("FAIL basic_table[%0d][%0d]: got %h required %h", i, t, a_lut4[i][t], e);
        end
      end
    do_cycle();
    checks++;
    if (lut_valid4 !== 1'b0 || act_ready4 !== 1'b1 || a_lut4[0][7] !== 16'h3F00) begin
      errors++;
      $display("FAIL basic_oneshot: got valid=%b ready=%b lut07=%h required 0 1 3f00", lut_valid4, act_ready4, a_lut4[0][7]);
    end
  endtask

  task automatic test_backpressure();
    int lat, v;
    logic [15:0] e;
    logic [1:0][7:0][15:0] snap;
    randgrp(1);
    grp[1][0] = '{16, 32, 8, 4};
    load4(1);
    lut_ready4 = 1'b0;
    act_valid4 = 1'b1;
    do_cycle();
    act4 = {$urandom, $urandom, $urandom, $urandom};
    wait_valid4(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d required 3", lat);
    end
    snap = a_lut4;
    for (int c = 0; c < 5; c++) begin
      do_cycle();
      checks++;
      if (lut_valid4 !== 1'b1 || act_ready4 !== 1'b0 || a_lut4 !== snap) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b lut=%h required 1 0 %h", c, lut_valid4, act_ready4, a_lut4, snap);
      end
    end
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < 8; t++) begin
        v = expv(1, i, t, 4);
        e = q2h(v);
        checks++;
        if ((v == 0) ? (a_lut4[i][t][14:0] !== 15'h0) : (a_lut4[i][t] !== e)) begin
          errors++;
          $display("FAIL bp_table[%0d][%0d]: got %h required %h", i, t, a_lut4[i][t], e);
        end
      end
    act_valid4 = 1'b0;
    lut_ready4 = 1'b1;
    do_cycle();
    checks++;
    if (lut_valid4 !== 1'b0 || act_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b required 0 1", lut_valid4, act_ready4);
    end
  endtask

  task automatic test_back_to_back();
    int nacc, n, v, g;
    int acc_cyc[4];
    logic [15:0] e;
    bit acc;
    for (int k = 2; k < 6; k++) randgrp(k);
    acc_cyc = '{0, 0, 0, 0};
    nacc = 0;
    lut_ready4 = 1'b1;
    load4(2);
    act_valid4 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      acc = (act_ready4 === 1'b1);
      do_cycle();
      if (acc) begin
        if (nacc < 4) acc_cyc[nacc] = c;
        nacc++;
        if (nacc < 4) load4(2 + nacc);
      end
      if (lut_valid4 === 1'b1 && nacc > 0 && nacc <= 4) begin
        g = 2 + nacc - 1;
        for (int i = 0; i < 2; i++)
          for (int t = 0; t < 8; t++) begin
            v = expv(g, i, t, 4);
            e = q2h(v);
            checks++;
            if ((v == 0) ? (a_lut4[i][t][14:0] !== 15'h0) : (a_lut4[i][t] !== e)) begin
              errors++;
              $display("FAIL b2b_table g%0d [%0d][%0d]: got %h required %h", g, i, t, a_lut4[i][t], e);
            end
          end
      end
    end
    act_valid4 = 1'b0;
    checks++;
    if (nacc != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 4", nacc);
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] != 5) begin
        errors++;
        $display("FAIL b2b_period %0d: got %0d required 5", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    n = 0;
    while (act_ready4 !== 1'b1 && n < 20) begin
      do_cycle();
      n++;
    end
    checks++;
    if (act_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drain: act_ready=%b required 1", act_ready4);
    end
  endtask

  task automatic test_row_independence();
    int lat, v;
    logic [15:0] e;
    grp[6][0] = '{16, 32, 8, 4};
    grp[6][1] = '{0, 0, 0, 0};
    load4(6);
    lut_ready4 = 1'b1;
    act_valid4 = 1'b1;
    do_cycle();
    act_valid4 = 1'b0;
    wait_valid4(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL rowind_latency: got %0d required 3", lat);
    end
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (a_lut4[1][t][14:0] !== 15'h0) begin
        errors++;
        $display("FAIL rowind_zero[1][%0d]: got %h required +/-0", t, a_lut4[1][t]);
      end
      v = expv(6, 0, t, 4);
      e = q2h(v);
      checks++;
      if (a_lut4[0][t] !== e) begin
        errors++;
        $display("FAIL rowind_row0[%0d]: got %h required %h", t, a_lut4[0][t], e);
      end
    end
    do_cycle();
  endtask

  task automatic test_reset_mid_build();
    int lat, v;
    logic [15:0] e;
    randgrp(7);
    load4(7);
    lut_ready4 = 1'b1;
    act_valid4 = 1'b1;
    do_cycle();
    act_valid4 = 1'b0;
    do_cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (lut_valid4 !== 1'b0 || act_ready4 !== 1'b1 || a_lut4 !== '0) begin
      errors++;
      $display("FAIL midrst_state: got valid=%b ready=%b lut=%h required 0 1 0", lut_valid4, act_ready4, a_lut4);
    end
    #2;
    rst_n = 1'b1;
    do_cycle();
    randgrp(7);
    load4(7);
    act_valid4 = 1'b1;
    do_cycle();
    act_valid4 = 1'b0;
    wait_valid4(lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL midrst_latency: got %0d required 3", lat);
    end
    for (int i = 0; i < 2; i++)
      for (int t = 0; t < 8; t++) begin
        v = expv(7, i, t, 4);
        e = q2h(v);
        checks++;
        if ((v == 0) ? (a_lut4[i][t][14:0] !== 15'h0) : (a_lut4[i][t] !== e)) begin
          errors++;
          $display("FAIL midrst_table[%0d][%0d]: got %h required %h", i, t, a_lut4[i][t], e);
        end
      end
    do_cycle();
  endtask

  task automatic test_random();
    int lat, v, g, d;
    logic [15:0] e;
    for (int it = 0; it < 6; it++) begin
      g = 8 + it;
      randgrp(g);
      load4(g);
      lut_ready4 = 1'b0;
      act_valid4 = 1'b1;
      do_cycle();
      act_valid4 = 1'b0;
      act4 = {$urandom, $urandom, $urandom, $urandom};
      wait_valid4(lat);
      checks++;
      if (lat != 3) begin
        errors++;
        $display("FAIL rand%0d_latency: got %0d required 3", it, lat);
      end
      for (int i = 0; i < 2; i++)
        for (int t = 0; t < 8; t++) begin
          v = expv(g, i, t, 4);
          e = q2h(v);
          checks++;
          if ((v == 0) ? (a_lut4[i][t][14:0] !== 15'h0) : (a_lut4[i][t] !== e)) begin
            errors++;
            $display("FAIL rand%0d_table[%0d][%0d]: got %h required %h", it, i, t, a_lut4[i][t], e);
          end
        end
      d = int'($urandom_range(3, 0));
      for (int c = 0; c < d; c++) begin
        do_cycle();
        checks++;
        if (lut_valid4 !== 1'b1) begin
          errors++;
          $display("FAIL rand%0d_hold: lut_valid=%b required 1", it, lut_valid4);
        end
      end
      lut_ready4 = 1'b1;
      do_cycle();
      lut_ready4 = 1'b0;
      checks++;
      if (act_ready4 !== 1'b1 || lut_valid4 !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_release: got ready=%b valid=%b required 1 0", it, act_ready4, lut_valid4);
      end
    end
  endtask

  task automatic test_k2();
    int lat, r0, r1, v;
    logic [15:0] e;
    r0 = int'($urandom_range(128, 0)) - 64;
    r1 = int'($urandom_range(128, 0)) - 64;
    act2[0][0] = q2h(16);
    act2[0][1] = q2h(32);
    act2[1][0] = q2h(r0);
    act2[1][1] = q2h(r1);
    lut_ready2 = 1'b1;
    act_valid2 = 1'b1;
    do_cycle();
    act_valid2 = 1'b0;
    act2 = {$urandom, $urandom};
    lat = 0;
    do begin
      do_cycle();
      lat++;
    end while (lut_valid2 !== 1'b1 && lat < 20);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL k2_latency: got %0d required 1", lat);
    end
    checks++;
    if (a_lut2[0][0] !== 16'hC200 || a_lut2[0][1] !== 16'h3C00) begin
      errors++;
      $display("FAIL k2_row0: got %h %h required c200 3c00", a_lut2[0][0], a_lut2[0][1]);
    end
    for (int t = 0; t < 2; t++) begin
      v = (t == 0) ? (-r0 - r1) : (-r0 + r1);
      e = q2h(v);
      checks++;
      if ((v == 0) ? (a_lut2[1][t][14:0] !== 15'h0) : (a_lut2[1][t] !== e)) begin
        errors++;
        $display("FAIL k2_row1[%0d]: got %h required %h", t, a_lut2[1][t], e);
      end
    end
    do_cycle();
    checks++;
    if (lut_valid2 !== 1'b0 || act_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL k2_release: got valid=%b ready=%b required 0 1", lut_valid2, act_ready2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_row_independence();
    test_reset_mid_build();
    test_random();
    test_k2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
